// File: rtl/risc_run_ctrl_if.sv
// Control/status bundle between the host (or bench) and the run controller.
// The master drives start/abort/core_halt; the slave (risc_run_ctrl) drives the rest.
interface risc_run_ctrl_if #(
    parameter int NUM_CORES = 2,
    parameter int CNT_W     = 32
);
    logic                         start;
    logic                         abort;
    logic [NUM_CORES-1:0]         core_halt;
    logic [NUM_CORES-1:0]         core_rst_n;
    logic                         busy;
    logic                         done;
    logic                         timeout;
    logic [NUM_CORES-1:0]         halt_mask;
    logic [CNT_W-1:0]             cycle_count;
    logic [NUM_CORES*CNT_W-1:0]   halt_stamp;

    modport master (
        output start, abort, core_halt,
        input  core_rst_n, busy, done, timeout, halt_mask, cycle_count, halt_stamp
    );

    modport slave (
        input  start, abort, core_halt,
        output core_rst_n, busy, done, timeout, halt_mask, cycle_count, halt_stamp
    );
endinterface

// File: rtl/risc_run_ctrl.sv
// Run controller: holds cores in reset, releases them, counts run cycles until all halt or timeout.
// Optional macro HALT_STAMP_EN builds per-core halt timestamp registers; otherwise halt_stamp is 0.
module risc_run_ctrl #(
    parameter int NUM_CORES  = 2,
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    risc_run_ctrl_if.slave     bus
);

    localparam int                RC_W     = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);
    localparam logic [RC_W-1:0]   RC_LAST  = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [RC_W-1:0]        rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]       cycle_count_q, cycle_count_d;
    logic [NUM_CORES-1:0]   halt_mask_q, halt_mask_d;
    logic                   timeout_q, timeout_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [NUM_CORES-1:0]   core_rst_n_q, core_rst_n_d;
    logic [NUM_CORES-1:0]   halt_merged;

    always_comb begin
        state_d       = state_q;
        rst_cnt_d     = rst_cnt_q;
        cycle_count_d = cycle_count_q;
        halt_mask_d   = halt_mask_q;
        timeout_d     = timeout_q;
        halt_merged   = halt_mask_q | bus.core_halt;

        // abort wins over everything; results stay visible until the next start
        if (bus.abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_d       = S_RESET;
                        rst_cnt_d     = '0;
                        cycle_count_d = '0;
                        halt_mask_d   = '0;
                        timeout_d     = 1'b0;
                    end
                end
                S_RESET: begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                    if (rst_cnt_q == RC_LAST) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    halt_mask_d = halt_merged;
                    // completion is tested first so a last halt on the final cycle is not a timeout
                    if (&halt_merged) begin
                        state_d   = S_DONE;
                        timeout_d = 1'b0;
                    end else if (cycle_count_q == CNT_LAST) begin
                        state_d   = S_DONE;
                        timeout_d = 1'b1;
                    end else begin
                        cycle_count_d = cycle_count_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d       = (state_d == S_RESET) || (state_d == S_RUN);
        done_d       = (state_d == S_DONE);
        core_rst_n_d = (state_d == S_RUN) ? '1 : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rst_cnt_q     <= '0;
            cycle_count_q <= '0;
            halt_mask_q   <= '0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            core_rst_n_q  <= '0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            cycle_count_q <= cycle_count_d;
            halt_mask_q   <= halt_mask_d;
            timeout_q     <= timeout_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            core_rst_n_q  <= core_rst_n_d;
        end
    end

    assign bus.core_rst_n  = core_rst_n_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timeout     = timeout_q;
    assign bus.halt_mask   = halt_mask_q;
    assign bus.cycle_count = cycle_count_q;

`ifdef HALT_STAMP_EN
    logic [NUM_CORES-1:0][CNT_W-1:0] stamp_q, stamp_d;
    logic                            run_clear;
    logic                            run_active;

    assign run_clear  = !bus.abort && bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign run_active = !bus.abort && (state_q == S_RUN);

    // a stamp is taken only on the first sampled halt of each core in a run
    always_comb begin
        stamp_d = stamp_q;
        if (run_clear) begin
            stamp_d = '0;
        end else if (run_active) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (bus.core_halt[i] && !halt_mask_q[i]) begin
                    stamp_d[i] = cycle_count_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stamp_q <= '0;
        end else begin
            stamp_q <= stamp_d;
        end
    end

    assign bus.halt_stamp = stamp_q;
`else
    assign bus.halt_stamp = '0;
`endif

endmodule
